// File: rtl/id_ex_reg_pkg.sv
// Pipeline constants shared by the control unit and the ID/EX, EX/MEM and MEM/WB registers.
// Holds the opcode width, the control bundle type and its NOP (bubble) encoding.
package id_ex_reg_pkg;

  localparam int unsigned OPCODE_W = 6;

  // One control word travels down the pipeline; EX/MEM and MEM/WB keep their subsets of it.
  typedef struct packed {
    logic                reg_dest;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                reg_write;
    logic                mem_to_reg;
    logic [OPCODE_W-1:0] alu_op;
  } ctrl_t;

  // All-zero control means no register write, no memory access and no branch.
  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic ctrl_is_nop(input ctrl_t c);
    return c == CTRL_NOP;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at all-ones instead of wrapping; synchronous active-high reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (enable && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: one-cycle capture of decode results, bubble insertion on flush,
// stall hold, and a saturating count of inserted bubbles.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned NB_OPCODE = OPCODE_W,
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_ADDR   = 5,
  parameter int unsigned NB_FUNCT  = 6,
  parameter int unsigned NB_CNT    = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_flush,
  input  logic                 i_reg_dest,
  input  logic                 i_alu_src,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_branch,
  input  logic                 i_reg_write,
  input  logic                 i_mem_to_reg,
  input  logic [NB_OPCODE-1:0] i_alu_op,
  input  logic [NB_DATA-1:0]   i_pc_plus4,
  input  logic [NB_DATA-1:0]   i_rs_data,
  input  logic [NB_DATA-1:0]   i_rt_data,
  input  logic [NB_DATA-1:0]   i_imm_ext,
  input  logic [NB_ADDR-1:0]   i_rs_addr,
  input  logic [NB_ADDR-1:0]   i_rt_addr,
  input  logic [NB_ADDR-1:0]   i_rd_addr,
  input  logic [NB_FUNCT-1:0]  i_funct,
  output logic                 o_reg_dest,
  output logic                 o_alu_src,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_branch,
  output logic                 o_reg_write,
  output logic                 o_mem_to_reg,
  output logic [NB_OPCODE-1:0] o_alu_op,
  output logic [NB_DATA-1:0]   o_pc_plus4,
  output logic [NB_DATA-1:0]   o_rs_data,
  output logic [NB_DATA-1:0]   o_rt_data,
  output logic [NB_DATA-1:0]   o_imm_ext,
  output logic [NB_ADDR-1:0]   o_rs_addr,
  output logic [NB_ADDR-1:0]   o_rt_addr,
  output logic [NB_ADDR-1:0]   o_rd_addr,
  output logic [NB_FUNCT-1:0]  o_funct,
  output logic                 o_valid,
  output logic [NB_CNT-1:0]    o_bubble_count
);

  ctrl_t               ctrl_in;
  ctrl_t               ctrl_q;
  logic                valid_q;
  logic [NB_DATA-1:0]  pc_plus4_q, rs_data_q, rt_data_q, imm_ext_q;
  logic [NB_ADDR-1:0]  rs_addr_q, rt_addr_q, rd_addr_q;
  logic [NB_FUNCT-1:0] funct_q;
  logic                bubble_inc;

  always_comb begin
    ctrl_in            = CTRL_NOP;
    ctrl_in.reg_dest   = i_reg_dest;
    ctrl_in.alu_src    = i_alu_src;
    ctrl_in.mem_read   = i_mem_read;
    ctrl_in.mem_write  = i_mem_write;
    ctrl_in.branch     = i_branch;
    ctrl_in.reg_write  = i_reg_write;
    ctrl_in.mem_to_reg = i_mem_to_reg;
    ctrl_in.alu_op     = i_alu_op;
  end

  // Priority per edge: reset, then stall hold, then flush, then normal load.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ctrl_q     <= CTRL_NOP;
      valid_q    <= 1'b0;
      pc_plus4_q <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_ext_q  <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      rd_addr_q  <= '0;
      funct_q    <= '0;
    end else if (i_enable) begin
      // Data and addresses load even on flush so the debug view of EX stays meaningful.
      pc_plus4_q <= i_pc_plus4;
      rs_data_q  <= i_rs_data;
      rt_data_q  <= i_rt_data;
      imm_ext_q  <= i_imm_ext;
      rs_addr_q  <= i_rs_addr;
      rt_addr_q  <= i_rt_addr;
      rd_addr_q  <= i_rd_addr;
      funct_q    <= i_funct;
      if (i_flush) begin
        ctrl_q  <= CTRL_NOP;
        valid_q <= 1'b0;
      end else begin
        ctrl_q  <= ctrl_in;
        valid_q <= 1'b1;
      end
    end
  end

  assign bubble_inc = i_enable & i_flush;

  sat_counter #(
    .WIDTH (NB_CNT)
  ) u_bubble_cnt (
    .clock  (i_clock),
    .reset  (i_reset),
    .enable (bubble_inc),
    .count  (o_bubble_count)
  );

  assign o_reg_dest   = ctrl_q.reg_dest;
  assign o_alu_src    = ctrl_q.alu_src;
  assign o_mem_read   = ctrl_q.mem_read;
  assign o_mem_write  = ctrl_q.mem_write;
  assign o_branch     = ctrl_q.branch;
  assign o_reg_write  = ctrl_q.reg_write;
  assign o_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_alu_op     = ctrl_q.alu_op;
  assign o_pc_plus4   = pc_plus4_q;
  assign o_rs_data    = rs_data_q;
  assign o_rt_data    = rt_data_q;
  assign o_imm_ext    = imm_ext_q;
  assign o_rs_addr    = rs_addr_q;
  assign o_rt_addr    = rt_addr_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_funct      = funct_q;
  assign o_valid      = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: a reference model pushes expected EX state per edge into a
// queue, which is popped and compared just after each rising edge.
module tb_id_ex_reg;

  typedef struct packed {
    logic        reg_dest;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        reg_write;
    logic        mem_to_reg;
    logic [5:0]  alu_op;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [4:0]  rd_a;
    logic [5:0]  funct;
  } in_t;

  typedef struct packed {
    in_t        f;
    logic       valid;
    logic [3:0] cnt;
  } out_t;

  logic clk = 1'b0;
  logic i_reset, i_enable, i_flush;
  in_t  din;

  logic        o_reg_dest, o_alu_src, o_mem_read, o_mem_write, o_branch, o_reg_write;
  logic        o_mem_to_reg, o_valid;
  logic [5:0]  o_alu_op, o_funct;
  logic [31:0] o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr;
  logic [3:0]  o_bubble_count;

  int   checks = 0;
  int   failures = 0;
  out_t model_q = '0;
  out_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_reg #(
    .NB_OPCODE (6),
    .NB_DATA   (32),
    .NB_ADDR   (5),
    .NB_FUNCT  (6),
    .NB_CNT    (4)
  ) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_flush        (i_flush),
    .i_reg_dest     (din.reg_dest),
    .i_alu_src      (din.alu_src),
    .i_mem_read     (din.mem_read),
    .i_mem_write    (din.mem_write),
    .i_branch       (din.branch),
    .i_reg_write    (din.reg_write),
    .i_mem_to_reg   (din.mem_to_reg),
    .i_alu_op       (din.alu_op),
    .i_pc_plus4     (din.pc),
    .i_rs_data      (din.rs),
    .i_rt_data      (din.rt),
    .i_imm_ext      (din.imm),
    .i_rs_addr      (din.rs_a),
    .i_rt_addr      (din.rt_a),
    .i_rd_addr      (din.rd_a),
    .i_funct        (din.funct),
    .o_reg_dest     (o_reg_dest),
    .o_alu_src      (o_alu_src),
    .o_mem_read     (o_mem_read),
    .o_mem_write    (o_mem_write),
    .o_branch       (o_branch),
    .o_reg_write    (o_reg_write),
    .o_mem_to_reg   (o_mem_to_reg),
    .o_alu_op       (o_alu_op),
    .o_pc_plus4     (o_pc_plus4),
    .o_rs_data      (o_rs_data),
    .o_rt_data      (o_rt_data),
    .o_imm_ext      (o_imm_ext),
    .o_rs_addr      (o_rs_addr),
    .o_rt_addr      (o_rt_addr),
    .o_rd_addr      (o_rd_addr),
    .o_funct        (o_funct),
    .o_valid        (o_valid),
    .o_bubble_count (o_bubble_count)
  );

  function automatic out_t model(input out_t cur, input in_t d, input logic rst, input logic en,
                                 input logic fl);
    out_t n = cur;
    if (rst) begin
      n = '0;
    end else if (en) begin
      n.f = d;
      if (fl) begin
        n.f.reg_dest   = 1'b0;
        n.f.alu_src    = 1'b0;
        n.f.mem_read   = 1'b0;
        n.f.mem_write  = 1'b0;
        n.f.branch     = 1'b0;
        n.f.reg_write  = 1'b0;
        n.f.mem_to_reg = 1'b0;
        n.f.alu_op     = 6'h00;
        n.valid        = 1'b0;
        if (n.cnt != 4'hF) n.cnt = n.cnt + 4'd1;
      end else begin
        n.valid = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic compare();
    out_t act, exp;
    exp = exp_q.pop_front();
    act.f.reg_dest   = o_reg_dest;
    act.f.alu_src    = o_alu_src;
    act.f.mem_read   = o_mem_read;
    act.f.mem_write  = o_mem_write;
    act.f.branch     = o_branch;
    act.f.reg_write  = o_reg_write;
    act.f.mem_to_reg = o_mem_to_reg;
    act.f.alu_op     = o_alu_op;
    act.f.pc         = o_pc_plus4;
    act.f.rs         = o_rs_data;
    act.f.rt         = o_rt_data;
    act.f.imm        = o_imm_ext;
    act.f.rs_a       = o_rs_addr;
    act.f.rt_a       = o_rt_addr;
    act.f.rd_a       = o_rd_addr;
    act.f.funct      = o_funct;
    act.valid        = o_valid;
    act.cnt          = o_bubble_count;
    check("ctrl", 128'({act.f.reg_dest, act.f.alu_src, act.f.mem_read, act.f.mem_write,
                        act.f.branch, act.f.reg_write, act.f.mem_to_reg, act.f.alu_op}),
                  128'({exp.f.reg_dest, exp.f.alu_src, exp.f.mem_read, exp.f.mem_write,
                        exp.f.branch, exp.f.reg_write, exp.f.mem_to_reg, exp.f.alu_op}));
    check("data", {act.f.pc, act.f.rs, act.f.rt, act.f.imm},
                  {exp.f.pc, exp.f.rs, exp.f.rt, exp.f.imm});
    check("addr", 128'({act.f.rs_a, act.f.rt_a, act.f.rd_a, act.f.funct}),
                  128'({exp.f.rs_a, exp.f.rt_a, exp.f.rd_a, exp.f.funct}));
    check("valid", 128'(act.valid), 128'(exp.valid));
    check("count", 128'(act.cnt), 128'(exp.cnt));
  endtask

  task automatic step(input logic rst, input logic en, input logic fl);
    i_reset  = rst;
    i_enable = en;
    i_flush  = fl;
    model_q  = model(model_q, din, rst, en, fl);
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic rand_in();
    din.reg_dest   = 1'($urandom_range(0, 1));
    din.alu_src    = 1'($urandom_range(0, 1));
    din.mem_read   = 1'($urandom_range(0, 1));
    din.mem_write  = 1'($urandom_range(0, 1));
    din.branch     = 1'($urandom_range(0, 1));
    din.reg_write  = 1'($urandom_range(0, 1));
    din.mem_to_reg = 1'($urandom_range(0, 1));
    din.alu_op     = 6'($urandom_range(0, 63));
    din.pc         = $urandom();
    din.rs         = $urandom();
    din.rt         = $urandom();
    din.imm        = $urandom();
    din.rs_a       = 5'($urandom_range(0, 31));
    din.rt_a       = 5'($urandom_range(0, 31));
    din.rd_a       = 5'($urandom_range(0, 31));
    din.funct      = 6'($urandom_range(0, 63));
  endtask

  initial begin
    // Reset with every input forced high.
    din = '1;
    step(1'b1, 1'b1, 1'b1);

    // R-type load.
    din = '0;
    din.reg_dest  = 1'b1;
    din.reg_write = 1'b1;
    din.rs        = 32'h0000_0005;
    din.rt        = 32'h0000_0003;
    din.rd_a      = 5'd8;
    din.pc        = 32'h0000_0004;
    step(1'b0, 1'b1, 1'b0);
    check("rtype_rd", 128'(o_rd_addr), 128'(5'd8));

    // LW flushed into a bubble.
    din = '0;
    din.mem_read   = 1'b1;
    din.mem_to_reg = 1'b1;
    din.reg_write  = 1'b1;
    din.alu_op     = 6'h23;
    din.pc         = 32'h0000_0100;
    step(1'b0, 1'b1, 1'b1);
    check("flush_pc", 128'(o_pc_plus4), 128'(32'h0000_0100));

    // ADDI load, then three stalled edges with different inputs and flush high.
    din = '0;
    din.alu_src   = 1'b1;
    din.reg_write = 1'b1;
    din.alu_op    = 6'h08;
    din.imm       = 32'h0000_0010;
    din.pc        = 32'h0000_0200;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rand_in();
      step(1'b0, 1'b0, 1'b1);
    end
    check("hold_alu_op", 128'(o_alu_op), 128'(6'h08));
    check("hold_imm", 128'(o_imm_ext), 128'(32'h0000_0010));
    check("hold_count", 128'(o_bubble_count), 128'(4'd1));

    // Two more bubbles bring the count to 3, then reset wins over enable and flush.
    rand_in();
    step(1'b0, 1'b1, 1'b1);
    rand_in();
    step(1'b0, 1'b1, 1'b1);
    check("count_three", 128'(o_bubble_count), 128'(4'd3));
    rand_in();
    step(1'b1, 1'b1, 1'b1);
    rand_in();
    step(1'b0, 1'b1, 1'b0);

    // Random loads.
    for (int i = 0; i < 4; i++) begin
      rand_in();
      step(1'b0, 1'b1, 1'b0);
    end

    // Saturation: 17 consecutive flushes on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      rand_in();
      step(1'b0, 1'b1, 1'b1);
    end
    check("saturated", 128'(o_bubble_count), 128'(4'hF));

    // Reset while stalled, then resume loading.
    rand_in();
    step(1'b1, 1'b0, 1'b0);
    rand_in();
    step(1'b0, 1'b1, 1'b0);
    check("resume_valid", 128'(o_valid), 128'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
